mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store sequencer between the M-stage pipeline registers and the data-memory bus.
- Issues a single-outstanding request/acknowledge transaction per load or store, stalling the pipeline while the transaction is in flight.
- Builds store byte-enables and lane-replicated write data.
- For loads, right-aligns the returned word by byte offset. It then hands {LoadDataW, WidthSrcW} to the writeback width-reduction unit, which performs sign/zero extension.

Parameters:
TIMEOUT_CYCLES, 255, number of WAIT cycles without DMemAck before the transaction is abandoned and BusErr is raised (range 1..65535).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
MemReqM  input  1  M-stage instruction is a load or store
MemWriteM  input  1  1 = store, 0 = load (valid with MemReqM)
WidthSrcM  input  3  access width: 000 word, 010/110 half, 001/101 byte (bit2 = unsigned, passed through)
ALUResultM  input  32  effective byte address
WriteDataM  input  32  store data, right-justified
StallMem  output  1  hold IF/ID/EX/M stages this cycle
MisalignedM  output  1  one-cycle flag: illegal alignment, no bus access made
DMemReq  output  1  bus request, registered
DMemWe  output  1  bus write enable, registered
DMemAddr  output  32  word address {ALUResultM[31:2],2'b00}, registered
DMemWData  output  32  lane-replicated store data, registered
DMemBe  output  4  byte enables, registered
DMemAck  input  1  bus completion; sampled only in WAIT
DMemRData  input  32  read data, valid with DMemAck
LoadDataW  output  32  right-aligned load word for width reduction
WidthSrcW  output  3  WidthSrcM captured at issue
LoadValidW  output  1  one-cycle pulse, LoadDataW/WidthSrcW valid
BusErr  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All registered outputs are 0: DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe, LoadDataW, WidthSrcW, LoadValidW, BusErr.
  - Timeout counter = 0.
  - A reset mid-transaction abandons it immediately; DMemReq drops asynchronously.
- FSM states: IDLE, WAIT, DONE.
- Alignment is legal when:
  - width word and addr[1:0] = 00, or
  - width half and addr[0] = 0, or
  - width byte (any offset).
  - Any other WidthSrcM code is illegal.
- IDLE with MemReqM=1 and illegal alignment:
  - MisalignedM=1 (combinational) this cycle.
  - StallMem=0; no bus access; remain IDLE.
- IDLE with MemReqM=1 and legal alignment:
  - StallMem=1 (combinational).
  - Next edge: register DMemReq=1, DMemWe=MemWriteM, DMemAddr, DMemBe, DMemWData, offset=addr[1:0], WidthSrcW=WidthSrcM; clear counter; go to WAIT.
- Store encoding:
  - Word: Be=1111, WData=WriteDataM.
  - Half: Be=0011<<off, WData={2{WriteDataM[15:0]}}.
  - Byte: Be=0001<<off, WData={4{WriteDataM[7:0]}}.
- Load encoding: Be=1111.
- WAIT:
  - StallMem=1; outputs held stable.
  - On DMemAck=1: next edge DMemReq=0; for loads LoadDataW = DMemRData >> (8*off) with zero fill, LoadValidW=1; go to DONE.
  - Stores produce no LoadValidW.
  - Without ack: counter increments. When counter = TIMEOUT_CYCLES-1 and still no ack, next edge DMemReq=0, BusErr=1, LoadDataW=0, LoadValidW=1 for loads, go to DONE.
  - If ack and timeout coincide, ack wins.
- DONE (exactly 1 cycle):
  - StallMem=0; LoadValidW/BusErr asserted for this cycle only.
  - MemReqM is ignored, since it is still the completing instruction.
  - Next state: IDLE.
- DMemAck outside WAIT is ignored.
- Latency: a load with ack in its first WAIT cycle gives IDLE→WAIT→DONE, a 3-cycle M-stage occupancy.
- Max in-flight transactions: 1.

Test Plan:
- Reset mid-WAIT: issue load, assert reset_n=0 before ack → DMemReq=0 immediately, StallMem=0, state IDLE; a later ack is ignored.
- Load byte addr 0x1003, WidthSrcM=101, DMemRData=0xAABBCCDD acked on first WAIT cycle → DMemAddr=0x1000, DMemBe=1111, StallMem high 2 cycles, DONE cycle LoadDataW=0x000000AA, WidthSrcW=101, LoadValidW=1 for exactly 1 cycle.
- Store half addr 0x2002, WriteDataM=0x1234ABCD, ack after 3 WAIT cycles → DMemWe=1, DMemBe=1100, DMemWData=0xABCDABCD, stable across WAIT; no LoadValidW.
- Misaligned word load addr 0x3001 → MisalignedM=1 one cycle, StallMem=0, DMemReq never asserted.
- TIMEOUT_CYCLES=4, load with no ack → DMemReq high exactly 4 cycles, then BusErr=1 and LoadValidW=1 with LoadDataW=0 in DONE; ack arriving one cycle later ignored.
- Back-to-back loads (MemReqM held across DONE) → second transaction issues only from the IDLE cycle after DONE; both complete with correct data.

Source files
------------

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store sequencer. Issues one request/ack
//               bus transaction per M-stage load or store and stalls the
//               pipeline while it is outstanding. Stores get byte enables and
//               lane-replicated data. Loads are right-aligned by byte offset
//               and handed, together with the captured width code, to the
//               writeback width-reduction unit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   MemReqM, MemWriteM  : M-stage access request / store select
//   WidthSrcM[2:0]      : 000 word, x10 half, x01 byte (bit2 = unsigned)
//   ALUResultM[31:0]    : effective byte address
//   WriteDataM[31:0]    : right-justified store data
//   StallMem            : hold IF/ID/EX/M this cycle (combinational)
//   MisalignedM         : illegal alignment, no access made (combinational)
//   DMemReq/We/Addr/WData/Be : registered data-memory bus request
//   DMemAck, DMemRData  : bus completion and read data
//   LoadDataW, WidthSrcW, LoadValidW : right-aligned load result to writeback
//   BusErr              : one-cycle pulse when a transaction times out
// ============================================================================
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  WidthSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallMem,
  output logic        MisalignedM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBe,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic [31:0] LoadDataW,
  output logic [2:0]  WidthSrcW,
  output logic        LoadValidW,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value of the last WAIT cycle that may still accept an ack.
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_off;

  logic        w_is_word;
  logic        w_is_half;
  logic        w_is_byte;
  logic        w_legal;
  logic        w_issue;
  logic        w_ack;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;

  // Width decode; the unsigned bit only matters for word (which has none).
  assign w_is_word = (WidthSrcM == 3'b000);
  assign w_is_half = (WidthSrcM[1:0] == 2'b10);
  assign w_is_byte = (WidthSrcM[1:0] == 2'b01);

  assign w_legal = (w_is_word && (ALUResultM[1:0] == 2'b00)) ||
                   (w_is_half && !ALUResultM[0]) ||
                   w_is_byte;

  assign w_issue   = (r_state == S_IDLE) && MemReqM && w_legal;
  assign w_ack     = (r_state == S_WAIT) && DMemAck;
  // Ack takes priority over an expiring timeout in the same cycle.
  assign w_timeout = (r_state == S_WAIT) && !DMemAck && (r_cnt == c_TIMEOUT_LAST);

  // Store lane encoding; loads always fetch the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (MemWriteM) begin
      if (w_is_half) begin
        w_be    = 4'b0011 << ALUResultM[1:0];
        w_wdata = {2{WriteDataM[15:0]}};
      end else if (w_is_byte) begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
    end
  end

  // Right-align the returned word; upper bytes are zero-filled and the
  // writeback unit applies the real sign/zero extension.
  assign w_rshift = DMemRData >> {r_off, 3'b000};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    StallMem     = 1'b0;
    MisalignedM  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReqM) begin
          if (w_legal) begin
            StallMem     = 1'b1;
            w_next_state = S_WAIT;
          end else begin
            MisalignedM  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        StallMem = 1'b1;
        if (w_ack || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      // MemReqM still belongs to the completing instruction here.
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus request, timeout counter and load result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      DMemReq    <= 1'b0;
      DMemWe     <= 1'b0;
      DMemAddr   <= 32'd0;
      DMemWData  <= 32'd0;
      DMemBe     <= 4'd0;
      LoadDataW  <= 32'd0;
      WidthSrcW  <= 3'd0;
      LoadValidW <= 1'b0;
      BusErr     <= 1'b0;
      r_cnt      <= 16'd0;
      r_off      <= 2'd0;
    end else begin
      // Completion flags are single-cycle pulses covering the DONE cycle.
      LoadValidW <= 1'b0;
      BusErr     <= 1'b0;
      if (w_issue) begin
        DMemReq   <= 1'b1;
        DMemWe    <= MemWriteM;
        DMemAddr  <= {ALUResultM[31:2], 2'b00};
        DMemBe    <= w_be;
        DMemWData <= w_wdata;
        r_off     <= ALUResultM[1:0];
        WidthSrcW <= WidthSrcM;
        r_cnt     <= 16'd0;
      end else if (w_ack) begin
        DMemReq <= 1'b0;
        if (!DMemWe) begin
          LoadDataW  <= w_rshift;
          LoadValidW <= 1'b1;
        end
      end else if (w_timeout) begin
        DMemReq <= 1'b0;
        BusErr  <= 1'b1;
        if (!DMemWe) begin
          LoadDataW  <= 32'd0;
          LoadValidW <= 1'b1;
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4)
//               with directed scenarios and randomized transactions compared
//               against a byte-lane reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk;
  logic        reset_n;
  logic        MemReqM;
  logic        MemWriteM;
  logic [2:0]  WidthSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallMem;
  logic        MisalignedM;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemBe;
  logic        DMemAck;
  logic [31:0] DMemRData;
  logic [31:0] LoadDataW;
  logic [2:0]  WidthSrcW;
  logic        LoadValidW;
  logic        BusErr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .WidthSrcM  (WidthSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallMem   (StallMem),
    .MisalignedM(MisalignedM),
    .DMemReq    (DMemReq),
    .DMemWe     (DMemWe),
    .DMemAddr   (DMemAddr),
    .DMemWData  (DMemWData),
    .DMemBe     (DMemBe),
    .DMemAck    (DMemAck),
    .DMemRData  (DMemRData),
    .LoadDataW  (LoadDataW),
    .WidthSrcW  (WidthSrcW),
    .LoadValidW (LoadValidW),
    .BusErr     (BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: byte-lane view of an access
  // --------------------------------------------------------------------------
  function automatic int m_size(input logic [2:0] w);
    case (w)
      3'b000:         return 4;
      3'b010, 3'b110: return 2;
      3'b001, 3'b101: return 1;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] w, input logic [31:0] a);
    int s;
    s = m_size(w);
    if (s == 0) return 1'b0;
    return (int'(a[1:0]) % s) == 0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] w, input logic [31:0] a);
    logic [3:0] be;
    int s;
    int off;
    s   = m_size(w);
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) be[i] = !we || (i >= off && i < off + s);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] wd);
    logic [31:0] r;
    int s;
    s = m_size(w);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a);
    logic [31:0] r;
    int off;
    off = int'(a[1:0]);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = (j + off < 4) ? rd[8*(j+off) +: 8] : 8'h00;
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Transaction driver: records what the DUT did (no judgement here)
  // --------------------------------------------------------------------------
  logic        o_stall_issue, o_mis_issue, o_we, o_lv, o_buserr, o_done_stall;
  logic        o_lv_after, o_be_after, o_req_after;
  logic [31:0] o_addr, o_wdata, o_ldata;
  logic [3:0]  o_be;
  logic [2:0]  o_wsrc;
  int          o_req_cycles, o_stall_cycles, o_mis_cycles;
  bit          o_unstable, o_hang;

  // Starts just after a negedge with the DUT in IDLE; ack_delay is the WAIT
  // cycle index carrying the ack (-1 or >= T means none in time).
  task automatic run_txn(input bit we, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_delay,
                         input logic [31:0] rd, input bit hold);
    bit in_wait;
    int k;
    MemReqM = 1'b1; MemWriteM = we; WidthSrcM = w; ALUResultM = a; WriteDataM = wd;
    DMemAck = 1'b0;
    #1;
    o_stall_issue = StallMem; o_mis_issue = MisalignedM;
    o_stall_cycles = StallMem ? 1 : 0;
    o_req_cycles = 0; o_mis_cycles = 0; o_unstable = 0; o_hang = 0;
    o_lv = 0; o_buserr = 0; o_done_stall = 0;
    o_lv_after = 0; o_be_after = 0; o_req_after = 0;
    if (!o_stall_issue) begin
      o_mis_cycles = MisalignedM ? 1 : 0;
      @(negedge clk); MemReqM = 1'b0; #1;
      o_req_after  = DMemReq;
      o_mis_cycles += MisalignedM ? 1 : 0;
      @(negedge clk); #1;
      o_req_after  = o_req_after | DMemReq;
      o_lv_after   = LoadValidW;
      return;
    end
    in_wait = 1; k = 0;
    while (in_wait) begin
      @(negedge clk); #1;
      if (!DMemReq) begin
        in_wait = 0;
      end else begin
        o_req_cycles++;
        if (StallMem) o_stall_cycles++;
        if (k == 0) begin
          o_addr = DMemAddr; o_be = DMemBe; o_wdata = DMemWData; o_we = DMemWe;
        end else if (DMemAddr !== o_addr || DMemBe !== o_be || DMemWData !== o_wdata || DMemWe !== o_we) begin
          o_unstable = 1;
        end
        DMemAck   = (k == ack_delay);
        DMemRData = DMemAck ? rd : $urandom;
        k++;
        if (k > 40) begin o_hang = 1; in_wait = 0; end
      end
    end
    if (o_hang) begin
      MemReqM = 1'b0; DMemAck = 1'b0;
      return;
    end
    // DONE cycle
    o_done_stall = StallMem;
    if (StallMem) o_stall_cycles++;
    o_lv = LoadValidW; o_ldata = LoadDataW; o_wsrc = WidthSrcW; o_buserr = BusErr;
    DMemAck = 1'b1; DMemRData = $urandom;   // stray ack, must be ignored
    @(negedge clk); #1;
    o_lv_after = LoadValidW; o_be_after = BusErr; o_req_after = DMemReq;
    DMemAck = 1'b0;
    if (!hold) MemReqM = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0; MemReqM = 0; MemWriteM = 0; WidthSrcM = 0; ALUResultM = 0;
    WriteDataM = 0; DMemAck = 0; DMemRData = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({DMemReq, DMemWe, DMemBe} !== 6'd0) $display("FAIL reset_ctrl: got %b expected 000000", {DMemReq, DMemWe, DMemBe});
    else n_pass++;
    n_checks++;
    if ({DMemAddr, DMemWData, LoadDataW} !== 96'd0) $display("FAIL reset_data: got %h expected 0", {DMemAddr, DMemWData, LoadDataW});
    else n_pass++;
    n_checks++;
    if ({WidthSrcW, LoadValidW, BusErr, StallMem, MisalignedM} !== 7'd0)
      $display("FAIL reset_flags: got %b expected 0000000", {WidthSrcW, LoadValidW, BusErr, StallMem, MisalignedM});
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 3'b101, 32'h0000_1003, 32'hFFFF_FFFF, 0, 32'hAABB_CCDD, 1'b0);
    n_checks++;
    if (o_hang || o_addr !== 32'h0000_1000 || o_be !== 4'b1111)
      $display("FAIL ldb_bus: hang=%0d addr=%h be=%b expected addr=00001000 be=1111", o_hang, o_addr, o_be);
    else n_pass++;
    n_checks++;
    if (o_stall_cycles != 2) $display("FAIL ldb_stall: got %0d cycles expected 2", o_stall_cycles);
    else n_pass++;
    n_checks++;
    if (o_lv !== 1'b1 || o_ldata !== 32'h0000_00AA || o_wsrc !== 3'b101)
      $display("FAIL ldb_result: lv=%b data=%h wsrc=%b expected 1 000000aa 101", o_lv, o_ldata, o_wsrc);
    else n_pass++;
    n_checks++;
    if (o_lv_after !== 1'b0) $display("FAIL ldb_pulse: LoadValidW after DONE got %b expected 0", o_lv_after);
    else n_pass++;
  endtask

  task automatic test_store_half();
    // Ack on WAIT index 3 coincides with the timeout point: ack must win.
    run_txn(1'b1, 3'b010, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0, 1'b0);
    n_checks++;
    if (o_hang || o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD)
      $display("FAIL sth_bus: hang=%0d we=%b be=%b wdata=%h expected 1 1100 abcdabcd", o_hang, o_we, o_be, o_wdata);
    else n_pass++;
    n_checks++;
    if (o_unstable || o_req_cycles != 4) $display("FAIL sth_hold: unstable=%0d req_cycles=%0d expected 0 4", o_unstable, o_req_cycles);
    else n_pass++;
    n_checks++;
    if (o_lv !== 1'b0 || o_buserr !== 1'b0) $display("FAIL sth_done: lv=%b buserr=%b expected 0 0", o_lv, o_buserr);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 3'b000, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0);
    n_checks++;
    if (o_mis_issue !== 1'b1 || o_stall_issue !== 1'b0)
      $display("FAIL mis_flag: mis=%b stall=%b expected 1 0", o_mis_issue, o_stall_issue);
    else n_pass++;
    n_checks++;
    if (o_mis_cycles != 1 || o_req_after !== 1'b0 || o_lv_after !== 1'b0)
      $display("FAIL mis_noreq: mis_cycles=%0d req=%b lv=%b expected 1 0 0", o_mis_cycles, o_req_after, o_lv_after);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b000, 32'h0000_4000, 32'h0, -1, 32'h0, 1'b0);
    n_checks++;
    if (o_hang || o_req_cycles != T) $display("FAIL tmo_req: hang=%0d req_cycles=%0d expected %0d", o_hang, o_req_cycles, T);
    else n_pass++;
    n_checks++;
    if (o_buserr !== 1'b1 || o_lv !== 1'b1 || o_ldata !== 32'd0)
      $display("FAIL tmo_done: buserr=%b lv=%b data=%h expected 1 1 00000000", o_buserr, o_lv, o_ldata);
    else n_pass++;
    n_checks++;
    if (o_be_after !== 1'b0 || o_lv_after !== 1'b0 || o_req_after !== 1'b0 || o_stall_cycles != T + 1)
      $display("FAIL tmo_after: buserr=%b lv=%b req=%b stall=%0d expected 0 0 0 %0d",
               o_be_after, o_lv_after, o_req_after, o_stall_cycles, T + 1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2;
    rd1 = $urandom; rd2 = $urandom;
    run_txn(1'b0, 3'b000, 32'h0000_5000, 32'h0, 1, rd1, 1'b1);
    n_checks++;
    if (o_hang || o_lv !== 1'b1 || o_ldata !== rd1) $display("FAIL b2b_first: lv=%b data=%h expected 1 %h", o_lv, o_ldata, rd1);
    else n_pass++;
    n_checks++;
    if (o_done_stall !== 1'b0 || o_req_after !== 1'b0)
      $display("FAIL b2b_gap: done_stall=%b req_in_idle=%b expected 0 0", o_done_stall, o_req_after);
    else n_pass++;
    run_txn(1'b0, 3'b110, 32'h0000_6002, 32'h0, 0, rd2, 1'b0);
    n_checks++;
    if (o_hang || o_lv !== 1'b1 || o_ldata !== m_load(rd2, 32'h0000_6002) || o_wsrc !== 3'b110 || o_addr !== 32'h0000_6000)
      $display("FAIL b2b_second: lv=%b data=%h wsrc=%b addr=%h expected 1 %h 110 00006000",
               o_lv, o_ldata, o_wsrc, o_addr, m_load(rd2, 32'h0000_6002));
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    MemReqM = 1'b1; MemWriteM = 1'b0; WidthSrcM = 3'b000; ALUResultM = 32'h0000_7000; DMemAck = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (DMemReq !== 1'b1) $display("FAIL rst_issue: DMemReq got %b expected 1", DMemReq);
    else n_pass++;
    @(negedge clk); #1;
    reset_n = 1'b0; MemReqM = 1'b0;
    #1;
    n_checks++;
    if (DMemReq !== 1'b0 || StallMem !== 1'b0 || LoadValidW !== 1'b0)
      $display("FAIL rst_async: req=%b stall=%b lv=%b expected 0 0 0", DMemReq, StallMem, LoadValidW);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1; DMemAck = 1'b1; DMemRData = $urandom;
    bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (DMemReq || LoadValidW || StallMem || BusErr) bad = 1;
    end
    DMemAck = 1'b0;
    n_checks++;
    if (bad) $display("FAIL rst_late_ack: late ack produced activity, got 1 expected 0");
    else n_pass++;
  endtask

  task automatic test_random();
    bit          we;
    logic [2:0]  w;
    logic [31:0] a, wd, rd;
    int          d, exp_req;
    bit          tmo;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1));
      w  = 3'($urandom_range(0, 7));
      a  = $urandom; wd = $urandom; rd = $urandom;
      d  = $urandom_range(0, 5);
      run_txn(we, w, a, wd, d, rd, 1'b0);
      if (!m_legal(w, a)) begin
        n_checks++;
        if (o_mis_issue !== 1'b1 || o_stall_issue !== 1'b0 || o_req_after !== 1'b0)
          $display("FAIL rnd%0d_mis: mis=%b stall=%b req=%b expected 1 0 0", n, o_mis_issue, o_stall_issue, o_req_after);
        else n_pass++;
      end else begin
        tmo     = (d >= T);
        exp_req = tmo ? T : d + 1;
        n_checks++;
        if (o_hang || o_mis_issue !== 1'b0 || o_req_cycles != exp_req || o_stall_cycles != exp_req + 1 || o_unstable)
          $display("FAIL rnd%0d_seq: hang=%0d mis=%b req=%0d stall=%0d unstable=%0d expected 0 0 %0d %0d 0",
                   n, o_hang, o_mis_issue, o_req_cycles, o_stall_cycles, o_unstable, exp_req, exp_req + 1);
        else n_pass++;
        n_checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== we || o_be !== m_be(we, w, a))
          $display("FAIL rnd%0d_bus: addr=%h we=%b be=%b expected %h %b %b",
                   n, o_addr, o_we, o_be, {a[31:2], 2'b00}, we, m_be(we, w, a));
        else n_pass++;
        if (we) begin
          n_checks++;
          if (o_wdata !== m_wdata(w, wd)) $display("FAIL rnd%0d_wdata: got %h expected %h", n, o_wdata, m_wdata(w, wd));
          else n_pass++;
        end
        n_checks++;
        if (o_lv !== !we || o_buserr !== tmo || o_wsrc !== w || o_lv_after !== 1'b0 || o_be_after !== 1'b0)
          $display("FAIL rnd%0d_done: lv=%b buserr=%b wsrc=%b lv_after=%b be_after=%b expected %b %b %b 0 0",
                   n, o_lv, o_buserr, o_wsrc, o_lv_after, o_be_after, !we, tmo, w);
        else n_pass++;
        if (!we) begin
          n_checks++;
          if (o_ldata !== (tmo ? 32'd0 : m_load(rd, a)))
            $display("FAIL rnd%0d_ldata: got %h expected %h", n, o_ldata, tmo ? 32'd0 : m_load(rd, a));
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
